// File: rtl/cp0_timer_ctrl.sv
// Coprocessor-0 controller with a Count/Compare timer.
// Holds SR, Cause, EPC, PRId and BadVAddr, and raises the interrupt/exception
// request for the M-stage instruction. The timer interrupt sits on pending
// line NUM_HWINT, directly above the external lines.
//
// req is a combinational request to the pipeline controller. It is not a
// valid/ready handshake. When req is high, the exception state (EXL, BD,
// ExcCode, EPC and possibly BadVAddr) is captured on the next rising edge,
// and any mtc0 issued in that cycle is dropped.
module cp0_timer_ctrl #(
  parameter int          NUM_HWINT = 6,
  parameter int          COUNT_DIV = 1,
  parameter logic [31:0] SR_RESET  = 32'h1000_0000,
  parameter logic [31:0] PRID      = 32'h0000_2022
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [4:0]           rd_addr,
  input  logic [4:0]           wr_addr,
  input  logic                 wr_en,
  input  logic [31:0]          wr_data,
  input  logic [31:0]          pc,
  input  logic                 bd_in,
  input  logic [4:0]           exc_code,
  input  logic [31:0]          bad_vaddr_in,
  input  logic [NUM_HWINT-1:0] hw_int,
  input  logic                 eret,
  output logic                 req,
  output logic [31:0]          epc_out,
  output logic [31:0]          rd_data,
  output logic                 exl,
  output logic                 timer_irq
);

  // Pending lines: the external interrupts plus one timer line.
  localparam int N  = NUM_HWINT + 1;
  localparam int PW = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(COUNT_DIV - 1);

  // SR keeps CU0, IM, EXL and IE. Every other bit is stored as zero.
  localparam logic [31:0] SR_MASK = 32'h1000_0003 | (((32'h1 << N) - 32'h1) << 8);

  localparam logic [4:0] A_BADVADDR = 5'd8;
  localparam logic [4:0] A_COUNT    = 5'd9;
  localparam logic [4:0] A_COMPARE  = 5'd11;
  localparam logic [4:0] A_SR       = 5'd12;
  localparam logic [4:0] A_CAUSE    = 5'd13;
  localparam logic [4:0] A_EPC      = 5'd14;
  localparam logic [4:0] A_PRID     = 5'd15;

  logic [31:0]          sr;
  logic [31:0]          sr_next;
  logic [31:0]          epc;
  logic [31:0]          bad_vaddr;
  logic [31:0]          count;
  logic [31:0]          compare;
  logic [31:0]          count_inc;
  logic [31:0]          cause;
  logic                 bd;
  logic                 ti;
  logic [NUM_HWINT-1:0] ip_hw;
  logic [4:0]           exc_code_r;
  logic [PW-1:0]        prescaler;

  logic [N-1:0]         ip_next;
  logic                 int_req;
  logic                 exc_req;
  logic                 wr_ok;
  logic                 wr_sr;
  logic                 wr_epc;
  logic                 wr_count;
  logic                 wr_compare;
  logic                 tick;
  logic                 ti_set;
  logic                 load_bva;

  // Request decode: interrupts use the live hw_int lines and the stored TI.
  always_comb begin
    ip_next  = {ti, hw_int};
    int_req  = (|(ip_next & sr[8 +: N])) & ~sr[1] & sr[0];
    exc_req  = (exc_code != 5'd0) & ~sr[1];
    req      = int_req | exc_req;
    load_bva = ~int_req & ((exc_code == 5'd4) | (exc_code == 5'd5));
  end

  // mtc0 decode. Writes are suppressed while an exception is being taken.
  always_comb begin
    wr_ok      = wr_en & ~req;
    wr_sr      = wr_ok & (wr_addr == A_SR);
    wr_epc     = wr_ok & (wr_addr == A_EPC);
    wr_count   = wr_ok & (wr_addr == A_COUNT);
    wr_compare = wr_ok & (wr_addr == A_COMPARE);
  end

  // Timer decode. TI is set only by a real increment, never by a Count load.
  always_comb begin
    tick      = (prescaler == PRE_MAX);
    count_inc = count + 32'd1;
    ti_set    = tick & ~wr_count & (count_inc == compare);
  end

  // Next SR. Taking an exception wins over eret. eret is applied after an
  // mtc0 SR write in the same cycle.
  always_comb begin
    sr_next = sr;
    if (req) begin
      sr_next[1] = 1'b1;
    end else begin
      if (wr_sr) begin
        sr_next = wr_data & SR_MASK;
      end
      if (eret) begin
        sr_next[1] = 1'b0;
      end
    end
  end

  // Exception state: SR, Cause fields, EPC, BadVAddr, sampled interrupt lines.
  always_ff @(posedge clk) begin
    if (reset) begin
      sr         <= SR_RESET;
      epc        <= 32'd0;
      bad_vaddr  <= 32'd0;
      bd         <= 1'b0;
      exc_code_r <= 5'd0;
      ip_hw      <= '0;
    end else begin
      sr    <= sr_next;
      ip_hw <= hw_int;
      if (req) begin
        bd         <= bd_in;
        exc_code_r <= int_req ? 5'd0 : exc_code;
        epc        <= bd_in ? (pc - 32'd4) : pc;
        if (load_bva) begin
          bad_vaddr <= bad_vaddr_in;
        end
      end else if (wr_epc) begin
        epc <= wr_data;
      end
    end
  end

  // Count/Compare timer with a prescaler. It keeps running while EXL is set.
  always_ff @(posedge clk) begin
    if (reset) begin
      prescaler <= '0;
      count     <= 32'd0;
      compare   <= 32'hFFFF_FFFF;
      ti        <= 1'b0;
    end else begin
      if (wr_count) begin
        prescaler <= '0;
        count     <= wr_data;
      end else if (tick) begin
        prescaler <= '0;
        count     <= count_inc;
      end else begin
        prescaler <= prescaler + PW'(1);
      end
      if (wr_compare) begin
        compare <= wr_data;
      end
      if (wr_compare) begin
        ti <= 1'b0;
      end else if (ti_set) begin
        ti <= 1'b1;
      end
    end
  end

  // Cause assembly: the timer line shares the top IP bit with TI.
  always_comb begin
    cause          = 32'd0;
    cause[31]      = bd;
    cause[30]      = ti;
    cause[8 +: N]  = {ti, ip_hw};
    cause[6:2]     = exc_code_r;
  end

  // mfc0 read mux over the stored registers. There is no write bypass.
  always_comb begin
    case (rd_addr)
      A_BADVADDR: rd_data = bad_vaddr;
      A_COUNT:    rd_data = count;
      A_COMPARE:  rd_data = compare;
      A_SR:       rd_data = sr;
      A_CAUSE:    rd_data = cause;
      A_EPC:      rd_data = epc;
      A_PRID:     rd_data = PRID;
      default:    rd_data = 32'd0;
    endcase
  end

  assign epc_out   = epc;
  assign exl       = sr[1];
  assign timer_irq = ti;

endmodule

// File: tb/tb_cp0_timer_ctrl.sv
// Testbench for cp0_timer_ctrl: directed scenarios plus randomized traffic
// checked against a cycle-indexed behavioural model.
module tb_cp0_timer_ctrl;

  localparam int NH  = 6;
  localparam int DIV = 2;
  localparam logic [31:0] SR_KEEP = 32'h1000_7F03;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset = 1'b1;
  logic [4:0]    rd_addr = '0, wr_addr = '0, exc_code = '0;
  logic          wr_en = 1'b0, bd_in = 1'b0, eret = 1'b0;
  logic [31:0]   wr_data = '0, pc = '0, bad_vaddr_in = '0;
  logic [NH-1:0] hw_int = '0;
  logic          req, exl, timer_irq;
  logic [31:0]   epc_out, rd_data;

  int n_checks = 0;
  int n_errors = 0;

  cp0_timer_ctrl #(.NUM_HWINT(NH), .COUNT_DIV(DIV),
                   .SR_RESET(32'h1000_0000), .PRID(32'h0000_2022)) dut (
    .clk(clk), .reset(reset), .rd_addr(rd_addr), .wr_addr(wr_addr),
    .wr_en(wr_en), .wr_data(wr_data), .pc(pc), .bd_in(bd_in),
    .exc_code(exc_code), .bad_vaddr_in(bad_vaddr_in), .hw_int(hw_int),
    .eret(eret), .req(req), .epc_out(epc_out), .rd_data(rd_data),
    .exl(exl), .timer_irq(timer_irq)
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", n_checks, n_errors);
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  // Count is held as (value loaded, edge index of the load). Its value at
  // edge t is the loaded value plus the number of whole prescaler periods.
  logic [31:0]   m_sr, m_epc, m_bva, m_compare, cnt_base;
  logic          m_bd, m_ti;
  logic [NH-1:0] m_ip;
  logic [4:0]    m_exc;
  longint        cyc = 0;
  longint        cnt_t0 = 0;

  function automatic logic [31:0] m_count(input longint t);
    return cnt_base + 32'((t - cnt_t0) / DIV);
  endfunction

  function automatic logic m_int_req();
    logic [NH:0] pend;
    pend = {m_ti, hw_int};
    return (|(pend & m_sr[8 +: NH+1])) && !m_sr[1] && m_sr[0];
  endfunction

  function automatic logic m_req();
    return m_int_req() || ((exc_code != 5'd0) && !m_sr[1]);
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a);
    logic [31:0] r;
    r = 32'd0;
    case (a)
      5'd8:  r = m_bva;
      5'd9:  r = m_count(cyc);
      5'd11: r = m_compare;
      5'd12: r = m_sr;
      5'd13: begin
        r[31] = m_bd; r[30] = m_ti; r[8 +: NH] = m_ip; r[8+NH] = m_ti; r[6:2] = m_exc;
      end
      5'd14: r = m_epc;
      5'd15: r = 32'h0000_2022;
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  task automatic model_update();
    logic ir, rq;
    logic [31:0] old_c, new_c;
    ir = m_int_req();
    rq = m_req();
    if (reset) begin
      m_sr = 32'h1000_0000; m_epc = 0; m_bva = 0; m_compare = 32'hFFFF_FFFF;
      m_bd = 0; m_ti = 0; m_ip = 0; m_exc = 0;
      cnt_base = 0; cnt_t0 = cyc + 1;
    end else begin
      old_c = m_count(cyc);
      new_c = m_count(cyc + 1);
      m_ip = hw_int;
      if (rq) begin
        m_sr[1] = 1'b1;
        m_bd    = bd_in;
        m_exc   = ir ? 5'd0 : exc_code;
        m_epc   = bd_in ? pc - 32'd4 : pc;
        if (!ir && (exc_code == 5'd4 || exc_code == 5'd5)) m_bva = bad_vaddr_in;
      end else begin
        if (wr_en && wr_addr == 5'd12) m_sr = wr_data & SR_KEEP;
        if (wr_en && wr_addr == 5'd14) m_epc = wr_data;
        if (eret) m_sr[1] = 1'b0;
      end
      if (!rq && wr_en && wr_addr == 5'd9) begin
        cnt_base = wr_data; cnt_t0 = cyc + 1;
      end else if (new_c != old_c && new_c == m_compare) begin
        m_ti = 1'b1;
      end
      if (!rq && wr_en && wr_addr == 5'd11) begin
        m_compare = wr_data; m_ti = 1'b0;
      end
    end
    cyc++;
  endtask

  // ---------------- driver tasks ----------------
  // Inputs change just after a falling edge. Outputs are sampled #1 later.
  task automatic step();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic idle();
    wr_en = 0; wr_addr = 0; wr_data = 0; exc_code = 0; bd_in = 0;
    eret = 0; hw_int = 0; pc = 0; bad_vaddr_in = 0; reset = 0;
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    wr_en = 1; wr_addr = a; wr_data = d;
    step();
    wr_en = 0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1;
    step();
    step();
    idle();
    rd_addr = 5'd12; #1;
    n_checks++; if (rd_data !== 32'h1000_0000) begin n_errors++; $display("FAIL reset_sr: got %h want %h", rd_data, 32'h1000_0000); end
    rd_addr = 5'd13; #1;
    n_checks++; if (rd_data !== 32'h0) begin n_errors++; $display("FAIL reset_cause: got %h want 0", rd_data); end
    rd_addr = 5'd11; #1;
    n_checks++; if (rd_data !== 32'hFFFF_FFFF) begin n_errors++; $display("FAIL reset_compare: got %h want ffffffff", rd_data); end
    rd_addr = 5'd15; #1;
    n_checks++; if (rd_data !== 32'h0000_2022) begin n_errors++; $display("FAIL reset_prid: got %h want 00002022", rd_data); end
    rd_addr = 5'd9; #1;
    n_checks++; if (rd_data !== 32'h0) begin n_errors++; $display("FAIL reset_count: got %h want 0", rd_data); end
    n_checks++; if (req !== 1'b0 || exl !== 1'b0 || epc_out !== 32'h0) begin n_errors++; $display("FAIL reset_outputs: req=%b exl=%b epc=%h want 0/0/0", req, exl, epc_out); end
    // read-only registers ignore mtc0; unmapped numbers read 0
    mtc0(5'd13, 32'hFFFF_FFFF);
    mtc0(5'd8, 32'hFFFF_FFFF);
    mtc0(5'd15, 32'h0);
    rd_addr = 5'd13; #1;
    n_checks++; if (rd_data !== 32'h0) begin n_errors++; $display("FAIL cause_readonly: got %h want 0", rd_data); end
    rd_addr = 5'd8; #1;
    n_checks++; if (rd_data !== 32'h0) begin n_errors++; $display("FAIL bva_readonly: got %h want 0", rd_data); end
    rd_addr = 5'd15; #1;
    n_checks++; if (rd_data !== 32'h0000_2022) begin n_errors++; $display("FAIL prid_readonly: got %h want 00002022", rd_data); end
    rd_addr = 5'd3; #1;
    n_checks++; if (rd_data !== 32'h0) begin n_errors++; $display("FAIL unmapped_read: got %h want 0", rd_data); end
  endtask

  task automatic test_interrupt();
    mtc0(5'd12, 32'h0000_0401);
    rd_addr = 5'd12; #1;
    n_checks++; if (rd_data !== 32'h0000_0401) begin n_errors++; $display("FAIL sr_write: got %h want 00000401", rd_data); end
    hw_int = 6'b000100; pc = 32'h0000_2000; #1;
    n_checks++; if (req !== 1'b1) begin n_errors++; $display("FAIL int_req: got %b want 1", req); end
    step();
    hw_int = 0; rd_addr = 5'd13; #1;
    n_checks++; if (rd_data !== 32'h0000_0400) begin n_errors++; $display("FAIL int_cause: got %h want 00000400", rd_data); end
    n_checks++; if (exl !== 1'b1 || epc_out !== 32'h0000_2000 || req !== 1'b0) begin n_errors++; $display("FAIL int_taken: exl=%b epc=%h req=%b want 1/00002000/0", exl, epc_out, req); end
    eret = 1;
    step();
    eret = 0; rd_addr = 5'd12; #1;
    n_checks++; if (rd_data !== 32'h0000_0401 || exl !== 1'b0) begin n_errors++; $display("FAIL eret: sr=%h exl=%b want 00000401/0", rd_data, exl); end
  endtask

  task automatic test_exception();
    exc_code = 5'd4; bd_in = 1; pc = 32'h3008; bad_vaddr_in = 32'h1235;
    wr_en = 1; wr_addr = 5'd14; wr_data = 32'hDEAD_BEEF; #1;
    n_checks++; if (req !== 1'b1) begin n_errors++; $display("FAIL exc_req: got %b want 1", req); end
    step();
    idle();
    rd_addr = 5'd14; #1;
    n_checks++; if (rd_data !== 32'h3004 || epc_out !== 32'h3004) begin n_errors++; $display("FAIL exc_epc: got %h/%h want 00003004", rd_data, epc_out); end
    rd_addr = 5'd13; #1;
    n_checks++; if ((rd_data & 32'h8000_007C) !== 32'h8000_0010) begin n_errors++; $display("FAIL exc_cause: got %h want bd=1 exccode=4", rd_data); end
    rd_addr = 5'd8; #1;
    n_checks++; if (rd_data !== 32'h1235) begin n_errors++; $display("FAIL exc_bva: got %h want 00001235", rd_data); end
    // second exception while EXL=1 is not taken
    exc_code = 5'd10; #1;
    n_checks++; if (req !== 1'b0) begin n_errors++; $display("FAIL exc_masked_by_exl: got %b want 0", req); end
    step();
    exc_code = 0; rd_addr = 5'd13; #1;
    n_checks++; if (rd_data[6:2] !== 5'd4) begin n_errors++; $display("FAIL exc_code_held: got %0d want 4", rd_data[6:2]); end
    eret = 1;
    step();
    eret = 0;
  endtask

  task automatic test_timer();
    logic bad;
    mtc0(5'd12, 32'h1000_4001);
    mtc0(5'd11, 32'd5);
    mtc0(5'd9, 32'd0);
    bad = 0;
    for (int i = 1; i <= 9; i++) begin
      step();
      #1;
      if (timer_irq !== 1'b0 || req !== 1'b0) bad = 1;
    end
    n_checks++; if (bad) begin n_errors++; $display("FAIL timer_early: timer_irq rose before 10 cycles"); end
    step();
    rd_addr = 5'd9; #1;
    n_checks++; if (timer_irq !== 1'b1 || rd_data !== 32'd5) begin n_errors++; $display("FAIL timer_fire: ti=%b count=%h want 1/00000005", timer_irq, rd_data); end
    n_checks++; if (req !== 1'b1) begin n_errors++; $display("FAIL timer_req: got %b want 1", req); end
    step();
    rd_addr = 5'd13; #1;
    n_checks++; if ((rd_data & 32'h4000_407C) !== 32'h4000_4000) begin n_errors++; $display("FAIL timer_cause: got %h want ti=1 ip6=1 exccode=0", rd_data); end
    mtc0(5'd11, 32'hFFFF_FFFF);
    #1;
    n_checks++; if (timer_irq !== 1'b0) begin n_errors++; $display("FAIL compare_clears_ti: got %b want 0", timer_irq); end
    eret = 1;
    step();
    eret = 0;
  endtask

  task automatic test_wrap();
    logic bad;
    mtc0(5'd12, 32'h1000_0000);
    mtc0(5'd11, 32'd0);
    mtc0(5'd9, 32'hFFFF_FFFF);
    step();
    #1;
    n_checks++; if (timer_irq !== 1'b0) begin n_errors++; $display("FAIL wrap_early: got %b want 0", timer_irq); end
    step();
    rd_addr = 5'd9; #1;
    n_checks++; if (timer_irq !== 1'b1 || rd_data !== 32'd0) begin n_errors++; $display("FAIL wrap_fire: ti=%b count=%h want 1/00000000", timer_irq, rd_data); end
    mtc0(5'd11, 32'h100);
    mtc0(5'd9, 32'h100);
    bad = 0;
    #1; if (timer_irq !== 1'b0) bad = 1;
    for (int i = 0; i < 4; i++) begin
      step();
      #1;
      if (timer_irq !== 1'b0) bad = 1;
    end
    n_checks++; if (bad) begin n_errors++; $display("FAIL count_load_no_ti: timer_irq set by Count write"); end
  endtask

  task automatic test_priority_reset();
    mtc0(5'd12, 32'h0000_0401);
    hw_int = 6'b000100; exc_code = 5'd12; pc = 32'h4000; #1;
    n_checks++; if (req !== 1'b1) begin n_errors++; $display("FAIL prio_req: got %b want 1", req); end
    step();
    rd_addr = 5'd13; #1;
    n_checks++; if (rd_data[6:2] !== 5'd0 || exl !== 1'b1) begin n_errors++; $display("FAIL prio_exccode: got %0d exl=%b want 0/1", rd_data[6:2], exl); end
    reset = 1;
    step();
    idle();
    rd_addr = 5'd12; #1;
    n_checks++; if (rd_data !== 32'h1000_0000 || exl !== 1'b0) begin n_errors++; $display("FAIL midreset_sr: got %h want 10000000", rd_data); end
    rd_addr = 5'd13; #1;
    n_checks++; if (rd_data !== 32'h0) begin n_errors++; $display("FAIL midreset_cause: got %h want 0", rd_data); end
    rd_addr = 5'd14; #1;
    n_checks++; if (rd_data !== 32'h0 || epc_out !== 32'h0) begin n_errors++; $display("FAIL midreset_epc: got %h want 0", rd_data); end
    rd_addr = 5'd11; #1;
    n_checks++; if (rd_data !== 32'hFFFF_FFFF || timer_irq !== 1'b0) begin n_errors++; $display("FAIL midreset_compare: got %h want ffffffff", rd_data); end
    rd_addr = 5'd9; #1;
    n_checks++; if (rd_data !== 32'h0) begin n_errors++; $display("FAIL midreset_count: got %h want 0", rd_data); end
  endtask

  task automatic test_random();
    logic [4:0] addr_tab [8];
    logic [31:0] exp;
    addr_tab = '{5'd8, 5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15, 5'd0};
    for (int i = 0; i < 600; i++) begin
      reset        = ($urandom_range(0, 199) == 0);
      hw_int       = ($urandom_range(0, 5) == 0) ? NH'($urandom) : '0;
      exc_code     = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(1, 31)) : 5'd0;
      bd_in        = 1'($urandom);
      pc           = $urandom & 32'hFFFF_FFFC;
      bad_vaddr_in = $urandom;
      eret         = ($urandom_range(0, 5) == 0);
      wr_en        = ($urandom_range(0, 2) == 0);
      wr_addr      = addr_tab[$urandom_range(0, 7)];
      wr_data      = $urandom;
      if (wr_addr == 5'd11) wr_data = m_count(cyc) + 32'($urandom_range(1, 6));
      if (wr_addr == 5'd9 && $urandom_range(0, 1) == 1) wr_data = m_compare - 32'($urandom_range(0, 3));
      if (wr_addr == 5'd12) wr_data = $urandom | 32'h0000_0001;
      if (wr_en && wr_addr == 5'd12) eret = 0;
      rd_addr = ($urandom_range(0, 4) == 0) ? 5'($urandom) : addr_tab[$urandom_range(0, 7)];
      #1;
      exp = m_read(rd_addr);
      n_checks++; if (rd_data !== exp) begin n_errors++; $display("FAIL rand_rd_data[%0d] addr=%0d: got %h want %h", i, rd_addr, rd_data, exp); end
      n_checks++; if (req !== m_req()) begin n_errors++; $display("FAIL rand_req[%0d]: got %b want %b", i, req, m_req()); end
      n_checks++; if (exl !== m_sr[1] || timer_irq !== m_ti || epc_out !== m_epc) begin n_errors++; $display("FAIL rand_outs[%0d]: exl=%b ti=%b epc=%h want %b/%b/%h", i, exl, timer_irq, epc_out, m_sr[1], m_ti, m_epc); end
      step();
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_interrupt();
    test_exception();
    test_timer();
    test_wrap();
    test_priority_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/cp0_timer_ctrl.md
Name: cp0_timer_ctrl

Overview:
- Parametrised coprocessor-0 controller that replaces the fixed six-interrupt CP0.
- Holds SR, Cause, EPC, PRId and BadVAddr, plus a built-in Count/Compare timer whose interrupt is one extra line in the pending vector.
- Raises the exception/interrupt request to the pipeline controller and supplies EPC for eret.
- Sits beside the M stage: exceptions are taken at M, mfc0/mtc0 access it from M.

Parameters:
NUM_HWINT, 6, external interrupt lines (1..7); timer line is index NUM_HWINT
COUNT_DIV, 1, Count increments once every COUNT_DIV cycles (1..256)
SR_RESET, 32'h1000_0000, SR value after reset
PRID, 32'h0000_2022, constant read from PRId

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
rd_addr  in  5  CP0 register number read (mfc0)
wr_addr  in  5  CP0 register number written (mtc0)
wr_en  in  1  mtc0 write enable
wr_data  in  32  mtc0 data
pc  in  32  PC of the M-stage instruction
bd_in  in  1  M-stage instruction is in a delay slot
exc_code  in  5  pending exception code; 0 means none
bad_vaddr_in  in  32  faulting address for AdEL/AdES
hw_int  in  NUM_HWINT  external interrupt levels
eret  in  1  clear EXL
req  out  1  take interrupt/exception this cycle
epc_out  out  32  EPC value
rd_data  out  32  read data
exl  out  1  SR.EXL
timer_irq  out  1  Cause.TI

Behaviour:
- Reset is synchronous and active-high. Fixed reset values: SR=SR_RESET; Cause=0; EPC=0; BadVAddr=0; Count=0; Compare=32'hFFFF_FFFF; prescaler=0.
- Register numbers: BadVAddr 8, Count 9, Compare 11, SR 12, Cause 13, EPC 14, PRId 15. Any other number reads 0.
- Field map, where N = NUM_HWINT+1:
  - SR: CU0[28], IM[8 +: N], EXL[1], IE[0]. Bits not in this list are stored as 0 on write.
  - Cause: BD[31], TI[30], IP[8 +: N], ExcCode[6:2].
  - IP[NUM_HWINT-1:0] is sampled from hw_int every non-reset cycle. IP[NUM_HWINT] = TI.
- Interrupt and exception requests (all combinational from registered state and inputs):
  - int_req = |(IP_next & IM) & !EXL & IE, where IP_next is {TI, hw_int}.
  - exc_req = (exc_code != 0) & !EXL.
  - req = int_req | exc_req.
- When req is high, the following registers update on the next edge:
  - ExcCode = int_req ? 0 : exc_code. Interrupt has priority over exception.
  - EXL=1.
  - BD=bd_in.
  - EPC = bd_in ? pc-4 : pc.
  - BadVAddr = bad_vaddr_in, only when !int_req and exc_code is 4 or 5.
- mtc0 is ignored in any cycle where req=1.
- Otherwise, wr_en writes the register selected by wr_addr:
  - Writable: SR, EPC, Count, Compare.
  - Cause, BadVAddr and PRId are read-only.
- eret clears EXL. If eret and req occur in the same cycle, req wins and EXL=1.
- Timer:
  - The prescaler counts 0..COUNT_DIV-1. At wrap, Count increments modulo 2^32 (32'hFFFF_FFFF -> 0).
  - TI is set on the edge where an increment makes Count == Compare.
  - TI holds until Compare is written; writing Compare clears TI in the same edge.
  - Writing Count loads wr_data and resets the prescaler to 0. That write overrides the increment in the same cycle and never sets TI.
  - The timer keeps running while EXL=1.
  - timer_irq = TI.
- Outputs:
  - rd_data is combinational from the currently stored registers.
  - A write becomes visible on read one cycle later; there is no write-to-read bypass.

Test Plan:
- Reset, then read SR, Cause, Compare, PRId -> 32'h1000_0000, 0, 32'hFFFF_FFFF, 32'h0000_2022; req=0 with exc_code=0.
- mtc0 SR=32'h0000_0401 (IM bit 10, IE), drive hw_int[2]=1 -> req=1 same cycle. Next cycle: ExcCode=0, EXL=1, EPC=pc, req=0. eret -> EXL=0.
- exc_code=4, bd_in=1, pc=32'h3008, bad_vaddr_in=32'h1235 -> req=1. Then EPC=32'h3004, BD=1, ExcCode=4, BadVAddr=32'h1235. A simultaneous mtc0 EPC is dropped.
- COUNT_DIV=2, Compare=5, Count written 0 -> TI rises exactly 10 cycles later. With SR.IM[8+NUM_HWINT]=1 and IE=1, req=1. Writing Compare clears TI.
- Count=32'hFFFF_FFFF, Compare=0 -> wraps to 0 and sets TI. A Count write equal to Compare does not set TI.
- hw_int and exc_code=12 together with IE=1 -> ExcCode=0. Assert reset mid-interrupt -> all registers return to reset values on the next edge.
